sprite_renderer: RTL and testbench

- Line-synchronous sprite engine: the next generation of the single-sprite drawer.
- Adds multi-frame animation, horizontal/vertical flip, transparent colour key, configurable graphic-memory read latency, and signed off-screen positioning.
- Sits between the display timing generator (sx/sy/line) and a sprite ROM/BRAM.
- Its pix/opaque outputs feed the priority mixer.

---
 rtl/sprite_renderer.sv | 191 +++++++++++++++++++
 tb/tb_sprite_renderer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sprite_renderer.sv
// sprite_renderer: line-synchronous sprite engine with animation frames,
// horizontal/vertical flip, transparent colour key, configurable graphic
// memory read latency and signed (partly off-screen) positioning.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   line          pulse at the start of each screen line
//   enable        sprite may start this frame
//   sx, sy        signed current screen position (sx includes blanking)
//   sprx, spry    signed sprite top-left corner
//   frame         animation frame select (ignored when FRAMES == 1)
//   flip_x/flip_y mirror horizontally / vertically
//   data_in       graphic memory read data, valid LAT cycles after addr
//   addr          graphic memory read address
//   pix, opaque   pixel colour (0 when not opaque) and visibility flag
//   drawing       address-phase DRAW state active
//   busy          engine not idle
//   done          one-cycle pulse when the sprite completes
module sprite_renderer #(
    parameter int WIDTH     = 8,
    parameter int HEIGHT    = 8,
    parameter int FRAMES    = 2,
    parameter int SCALE_X   = 1,
    parameter int SCALE_Y   = 1,
    parameter int COLR_BITS = 4,
    parameter int CORDW     = 16,
    parameter int LAT       = 2,
    parameter int TRANSP    = 0,
    parameter int ADDRW     = 7,
    localparam int FRW      = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    line,
    input  logic                    enable,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    input  logic [FRW-1:0]          frame,
    input  logic                    flip_x,
    input  logic                    flip_y,
    input  logic [COLR_BITS-1:0]    data_in,
    output logic [ADDRW-1:0]        addr,
    output logic [COLR_BITS-1:0]    pix,
    output logic                    opaque,
    output logic                    drawing,
    output logic                    busy,
    output logic                    done
);

    localparam int XW  = (WIDTH   > 1) ? $clog2(WIDTH)   : 1;
    localparam int YW  = (HEIGHT  > 1) ? $clog2(HEIGHT)  : 1;
    localparam int SXW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int SYW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

    localparam logic [XW-1:0]    OX_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0]    OY_LAST = YW'(HEIGHT - 1);
    localparam logic [SXW-1:0]   CX_LAST = SXW'(SCALE_X - 1);
    localparam logic [SYW-1:0]   CY_LAST = SYW'(SCALE_Y - 1);
    localparam logic [CORDW:0]   LEAD    = (CORDW+1)'(LAT + 1);
    localparam logic [ADDRW-1:0] A_W     = ADDRW'(WIDTH);
    localparam logic [ADDRW-1:0] A_WLAST = ADDRW'(WIDTH - 1);
    localparam logic [ADDRW-1:0] A_HLAST = ADDRW'(HEIGHT - 1);
    localparam logic [ADDRW-1:0] A_FRAME = ADDRW'(WIDTH * HEIGHT);

    typedef enum logic [2:0] {
        IDLE, START, AWAIT_POS, DRAW, NEXT_LINE, DONE
    } state_t;

    state_t state, state_next;

    logic [XW-1:0]           ox;
    logic [YW-1:0]           oy;
    logic [SXW-1:0]          cnt_x;
    logic [SYW-1:0]          cnt_y;
    logic signed [CORDW-1:0] sprx_l;
    logic [FRW-1:0]          frame_l;
    logic                    flip_x_l;
    logic                    flip_y_l;
    logic [LAT-1:0]          valid;
    logic [ADDRW-1:0]        addr_q;
    logic [ADDRW-1:0]        addr_draw;
    logic [ADDRW-1:0]        col;
    logic [ADDRW-1:0]        row;
    logic [CORDW:0]          sx_w;
    logic [CORDW:0]          trig_w;
    logic                    at_pos;
    logic                    col_last;
    logic                    row_last;

    // Start fetching LAT+1 cycles early so the first pixel lands at sx == sprx.
    // One extra bit keeps sprx near the negative limit from wrapping.
    assign sx_w     = {sx[CORDW-1], sx};
    assign trig_w   = {sprx_l[CORDW-1], sprx_l} - LEAD;
    assign at_pos   = (sx_w == trig_w);
    assign col_last = (ox == OX_LAST) && (cnt_x == CX_LAST);
    assign row_last = (oy == OY_LAST) && (cnt_y == CY_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        drawing    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (line && enable && (sy == spry)) state_next = START;
            end
            START:     state_next = AWAIT_POS;
            AWAIT_POS: if (at_pos) state_next = DRAW;
            DRAW: begin
                drawing = 1'b1;
                if (col_last) state_next = row_last ? DONE : NEXT_LINE;
            end
            NEXT_LINE: state_next = AWAIT_POS;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        col       = flip_x_l ? (A_WLAST - ADDRW'(ox)) : ADDRW'(ox);
        row       = flip_y_l ? (A_HLAST - ADDRW'(oy)) : ADDRW'(oy);
        addr_draw = ADDRW'(frame_l) * A_FRAME + row * A_W + col;
        // Outside DRAW the address freezes at the last fetched location.
        addr      = (state == DRAW) ? addr_draw : addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ox       <= '0;
            oy       <= '0;
            cnt_x    <= '0;
            cnt_y    <= '0;
            sprx_l   <= '0;
            frame_l  <= '0;
            flip_x_l <= 1'b0;
            flip_y_l <= 1'b0;
            valid    <= '0;
            addr_q   <= '0;
        end else begin
            valid[0] <= (state == DRAW);
            for (int unsigned i = 1; i < LAT; i++) valid[i] <= valid[i-1];
            case (state)
                START: begin
                    sprx_l   <= sprx;
                    frame_l  <= (FRAMES > 1) ? frame : '0;
                    flip_x_l <= flip_x;
                    flip_y_l <= flip_y;
                    oy       <= '0;
                    cnt_y    <= '0;
                end
                AWAIT_POS: begin
                    ox    <= '0;
                    cnt_x <= '0;
                end
                DRAW: begin
                    addr_q <= addr_draw;
                    if (cnt_x == CX_LAST) begin
                        cnt_x <= '0;
                        if (ox != OX_LAST) ox <= ox + 1'b1;
                    end else begin
                        cnt_x <= cnt_x + 1'b1;
                    end
                end
                NEXT_LINE: begin
                    if (cnt_y == CY_LAST) begin
                        cnt_y <= '0;
                        oy    <= oy + 1'b1;
                    end else begin
                        cnt_y <= cnt_y + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign opaque = valid[LAT-1] && (data_in != COLR_BITS'(TRANSP));
    assign pix    = opaque ? data_in : '0;

endmodule

// File: tb/tb_sprite_renderer.sv
// Directed bench for sprite_renderer: one instance at scale 1 and one at
// scale 2x2 share all inputs; each has its own LAT=2 memory returning addr[3:0].
module tb_sprite_renderer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, line, enable, flip_x, flip_y;
    logic [0:0]         frame;
    logic signed [15:0] sx, sy, sprx, spry;
    logic [3:0]         d1, d2, pix1, pix2;
    logic [6:0]         a1, a2;
    logic               op1, op2, dr1, dr2, bz1, bz2, dn1, dn2;
    logic [6:0]         p1 [2];
    logic [6:0]         p2 [2];

    int n_checks = 0;
    int n_fail   = 0;
    int dn1_cnt = 0, dn2_cnt = 0, dn1_y = 0, dn1_x = 0, dn2_y = 0, dn2_x = 0;
    int cur_px, cur_py, cur_fr;
    bit cur_fx, cur_fy;

    sprite_renderer #(.WIDTH(8), .HEIGHT(8), .FRAMES(2), .SCALE_X(1), .SCALE_Y(1),
                      .COLR_BITS(4), .CORDW(16), .LAT(2), .TRANSP(0), .ADDRW(7)) dut1 (
        .clk(clk), .rst(rst), .line(line), .enable(enable), .sx(sx), .sy(sy),
        .sprx(sprx), .spry(spry), .frame(frame), .flip_x(flip_x), .flip_y(flip_y),
        .data_in(d1), .addr(a1), .pix(pix1), .opaque(op1), .drawing(dr1),
        .busy(bz1), .done(dn1));

    sprite_renderer #(.WIDTH(8), .HEIGHT(8), .FRAMES(2), .SCALE_X(2), .SCALE_Y(2),
                      .COLR_BITS(4), .CORDW(16), .LAT(2), .TRANSP(0), .ADDRW(7)) dut2 (
        .clk(clk), .rst(rst), .line(line), .enable(enable), .sx(sx), .sy(sy),
        .sprx(sprx), .spry(spry), .frame(frame), .flip_x(flip_x), .flip_y(flip_y),
        .data_in(d2), .addr(a2), .pix(pix2), .opaque(op2), .drawing(dr2),
        .busy(bz2), .done(dn2));

    assign d1 = p1[1][3:0];
    assign d2 = p2[1][3:0];

    always @(posedge clk) begin
        p1[0] <= a1; p1[1] <= p1[0];
        p2[0] <= a2; p2[1] <= p2[0];
        if (dn1) begin dn1_cnt <= dn1_cnt + 1; dn1_y <= sy; dn1_x <= sx; end
        if (dn2) begin dn2_cnt <= dn2_cnt + 1; dn2_y <= sy; dn2_x <= sx; end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (sx=%0d sy=%0d)", tag, got, exp, sx, sy);
        end
    endtask

    // Expected fetch address at screen position (x, y); -1 when not fetching.
    function automatic int model_addr(int x, int y, int scx, int scy);
        int rx = x - (cur_px - 2);
        int ry = y - cur_py;
        int c, r;
        if (rx < 0 || ry < 0 || rx >= 8 * scx || ry >= 8 * scy) return -1;
        c = rx / scx;
        r = ry / scy;
        if (cur_fx) c = 7 - c;
        if (cur_fy) r = 7 - r;
        return (cur_fr * 64 + r * 8 + c) % 128;
    endfunction

    task automatic cycle(input int x, input int y, input bit ln, input bit chk);
        int ea, ep;
        @(posedge clk);
        #1;
        sx = 16'(x); sy = 16'(y); line = ln;
        #1;
        if (chk) begin
            ea = model_addr(x, y, 1, 1);
            check("d1.drawing", dr1, int'(ea >= 0));
            if (ea >= 0) check("d1.addr", a1, ea);
            ep = model_addr(x - 2, y, 1, 1);
            ep = (ep < 0) ? 0 : ep % 16;
            check("d1.opaque", op1, int'(ep != 0));
            check("d1.pix", pix1, ep);
            ea = model_addr(x, y, 2, 2);
            check("d2.drawing", dr2, int'(ea >= 0));
            if (ea >= 0) check("d2.addr", a2, ea);
            ep = model_addr(x - 2, y, 2, 2);
            ep = (ep < 0) ? 0 : ep % 16;
            check("d2.opaque", op2, int'(ep != 0));
            check("d2.pix", pix2, ep);
        end
    endtask

    task automatic run_line(input int y, input bit chk);
        for (int x = -160; x < 140; x++) cycle(x, y, x == -160, chk);
    endtask

    task automatic setup(input int px, input int fr, input bit fx, input bit fy);
        cur_px = px; cur_py = 50; cur_fr = fr; cur_fx = fx; cur_fy = fy;
        sprx = 16'(px); spry = 16'(50); frame = 1'(fr); flip_x = fx; flip_y = fy;
    endtask

    task automatic run_sprite(input int px, input int fr, input bit fx, input bit fy);
        int b1, b2;
        setup(px, fr, fx, fy);
        b1 = dn1_cnt; b2 = dn2_cnt;
        for (int y = 48; y < 68; y++) run_line(y, 1'b1);
        check("d1.done_count", dn1_cnt - b1, 1);
        check("d1.done_line", dn1_y, 57);
        check("d1.done_sx", dn1_x, px + 6);
        check("d2.done_count", dn2_cnt - b2, 1);
        check("d2.done_line", dn2_y, 65);
        check("d2.done_sx", dn2_x, px + 14);
        check("d1.busy_after", bz1, 0);
        check("d2.busy_after", bz2, 0);
    endtask

    initial begin
        int b1, b2;
        rst = 1'b1; line = 1'b0; enable = 1'b1;
        sx = '0; sy = '0;
        setup(100, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst.addr", a1, 0);
        check("rst.pix", pix1, 0);
        check("rst.opaque", op1, 0);
        check("rst.drawing", dr1, 0);
        check("rst.busy", bz1, 0);
        check("rst.done", dn1, 0);
        check("rst.busy2", bz2, 0);
        rst = 1'b0;

        // Disabled: the start line passes without waking the engine.
        enable = 1'b0;
        run_line(50, 1'b0);
        check("disabled.busy", bz1, 0);
        check("disabled.done", dn1_cnt, 0);
        enable = 1'b1;

        run_sprite(100, 0, 1'b0, 1'b0);
        run_sprite(100, 1, 1'b1, 1'b0);
        run_sprite(100, 1, 1'b1, 1'b1);
        run_sprite(-3, 0, 1'b0, 1'b0);

        // Reset in the middle of row 3, then a clean restart next frame.
        setup(100, 0, 1'b0, 1'b0);
        b1 = dn1_cnt; b2 = dn2_cnt;
        for (int y = 48; y < 53; y++) run_line(y, 1'b1);
        for (int x = -160; x < 102; x++) cycle(x, 53, x == -160, 1'b1);
        @(posedge clk); #1; sx = 16'(102); rst = 1'b1;
        @(posedge clk); #1; sx = 16'(103); rst = 1'b0; #1;
        check("abort.busy", bz1, 0);
        check("abort.opaque", op1, 0);
        check("abort.addr", a1, 0);
        check("abort.busy2", bz2, 0);
        check("abort.addr2", a2, 0);
        for (int x = 104; x < 140; x++) cycle(x, 53, 1'b0, 1'b0);
        for (int y = 54; y < 68; y++) run_line(y, 1'b0);
        check("abort.no_done1", dn1_cnt - b1, 0);
        check("abort.no_done2", dn2_cnt - b2, 0);
        run_sprite(100, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
